// File: rtl/move_seq_pkg.sv
// move_seq_pkg: shared state encoding, direction codes and LFSR taps for move_sequencer.
package move_seq_pkg;
  typedef enum logic [2:0] {IDLE, MOVE, SPAWN, COUNT, HALT} state_e;
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;
  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle rising pulse of the accepted level.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic rise
);
  logic s1_q, s2_q, acc_q, acc_d, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic hit;
  always_comb begin
    hit   = s2_q != acc_q && cnt_q == DEBOUNCE_CYCLES - 16'd1;
    cnt_d = (s2_q == acc_q || hit) ? '0 : cnt_q + 16'd1;
    acc_d = hit ? s2_q : acc_q;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      prev_q <= acc_q;
    end
  end
  assign rise = acc_q & ~prev_q;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: button-to-turn controller for the 2048 board (move, spawn, count over req/ack).
// Define MOVE_SEQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority L > R > U > D.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
  parameter logic [13:0] TURN_MAX        = 14'd9999,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnU,
  input  logic        btnD,
  output logic        move_req,
  output logic [1:0]  move_dir,
  input  logic        move_ack,
  input  logic        move_changed,
  output logic        spawn_req,
  output logic [3:0]  spawn_pos,
  input  logic        spawn_ack,
  input  logic        won,
  input  logic        lost,
  output logic [13:0] turns,
  output logic        busy
);
  logic [3:0] btns, rise, pending_q, pending_d;
  logic [1:0] dir_q, dir_d, grant;
  logic [3:0] pos_q, pos_d;
  logic [13:0] turns_q, turns_d;
  logic [15:0] lfsr_q, lfsr_d;
  state_e state_q, state_d;
  assign btns = {btnD, btnU, btnR, btnL};
  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .clr (clr),
      .btn (btns[g]),
      .rise(rise[g])
    );
  end
`ifdef MOVE_SEQ_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  // Walk down so the nearest direction after the last grant wins
  always_comb begin
    grant = last_q;
    for (int k = 4; k >= 1; k--)
      if (pending_q[2'(last_q + 2'(k))]) grant = 2'(last_q + 2'(k));
    last_d = (state_q == IDLE && state_d == MOVE) ? grant : last_q;
  end
  always_ff @(posedge clk) last_q <= clr ? DIR_D : last_d;
`else
  assign grant = pending_q[0] ? DIR_L : pending_q[1] ? DIR_R : pending_q[2] ? DIR_U : DIR_D;
`endif
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    turns_d   = turns_q;
    pending_d = '0;
    lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    case (state_q)
      IDLE: begin
        pending_d = |pending_q ? '0 : rise;
        state_d   = |pending_q ? MOVE : IDLE;
        dir_d     = |pending_q ? grant : dir_q;
      end
      MOVE: begin
        state_d = move_ack ? (move_changed ? SPAWN : IDLE) : MOVE;
        pos_d   = (move_ack && move_changed) ? lfsr_q[3:0] : pos_q;
      end
      SPAWN: state_d = spawn_ack ? COUNT : SPAWN;
      COUNT: begin
        state_d = IDLE;
        turns_d = turns_q < TURN_MAX ? turns_q + 14'd1 : turns_q;
      end
      default: state_d = HALT;
    endcase
    // Game end overrides everything, including a pending count
    if (won || lost) begin
      state_d   = HALT;
      turns_d   = turns_q;
      pending_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      dir_q     <= DIR_L;
      pos_q     <= '0;
      turns_q   <= '0;
      pending_q <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      turns_q   <= turns_d;
      pending_q <= pending_d;
      lfsr_q    <= lfsr_d;
    end
  end
  assign move_req  = state_q == MOVE;
  assign spawn_req = state_q == SPAWN;
  assign busy      = state_q != IDLE;
  assign move_dir  = dir_q;
  assign spawn_pos = pos_q;
  assign turns     = turns_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized turns checked against a turn-level model of move_sequencer.
module tb_move_sequencer;
  localparam int DEB = 8;
  localparam logic [13:0] TMAX = 14'd40;
  logic clk = 0, clr = 1;
  logic btnL = 0, btnR = 0, btnU = 0, btnD = 0;
  logic move_ack = 0, move_changed = 0, spawn_ack = 0, won = 0, lost = 0;
  logic move_req, spawn_req, busy;
  logic [1:0] move_dir;
  logic [3:0] spawn_pos;
  logic [13:0] turns;
  int n_checks = 0, n_fail = 0, req_rises = 0, m_turns = 0, m_last = 3;
  logic req_prev = 0;
  logic [15:0] m_lfsr;

  move_sequencer #(.DEBOUNCE_CYCLES(16'(DEB)), .TURN_MAX(TMAX), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .clr(clr), .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
    .move_req(move_req), .move_dir(move_dir), .move_ack(move_ack), .move_changed(move_changed),
    .spawn_req(spawn_req), .spawn_pos(spawn_pos), .spawn_ack(spawn_ack),
    .won(won), .lost(lost), .turns(turns), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) m_lfsr <= clr ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  always @(posedge clk) begin
    #1;
    if (move_req && !req_prev) req_rises++;
    req_prev = move_req;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_btn(input logic [3:0] m);
    {btnD, btnU, btnR, btnL} = m;
  endtask
  task automatic do_reset;
    set_btn(4'd0);
    {move_ack, move_changed, spawn_ack, won, lost} = '0;
    clr = 1; cyc(2); clr = 0;
    m_turns = 0; m_last = 3;
  endtask
  function automatic logic [1:0] exp_grant(input logic [3:0] m);
`ifdef MOVE_SEQ_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (m[(m_last + k) % 4]) return 2'((m_last + k) % 4);
`else
    for (int d = 0; d < 4; d++) if (m[d]) return 2'(d);
`endif
    return 2'd0;
  endfunction
  task automatic wait_req(output bit got);
    got = 0;
    for (int i = 0; i < DEB + 20 && !got; i++) begin
      cyc(1);
      got = move_req;
    end
  endtask
  // One full turn: press, hold move for d1 cycles, ack, optionally spawn after d2 cycles, then settle.
  task automatic run_turn(input logic [3:0] m, input bit chg, input int d1, input int d2,
                          output bit got, output logic [1:0] dir, output bit dir_ok,
                          output bit spawned, output logic [3:0] pos, output logic [3:0] exp_pos,
                          output bit pos_ok, output bit idle_after);
    set_btn(m); wait_req(got); set_btn(4'd0);
    dir = move_dir; dir_ok = 1; spawned = 0; pos = 0; exp_pos = 0; pos_ok = 1; idle_after = 0;
    if (!got) return;
    repeat (d1) begin cyc(1); if (move_dir !== dir || !move_req) dir_ok = 0; end
    move_ack = 1; move_changed = chg; exp_pos = m_lfsr[3:0];
    cyc(1); move_ack = 0; move_changed = 0;
    spawned = spawn_req;
    if (spawned) begin
      pos = spawn_pos;
      repeat (d2) begin cyc(1); if (spawn_pos !== pos || !spawn_req) pos_ok = 0; end
      spawn_ack = 1; cyc(1); spawn_ack = 0; cyc(1);
    end
    idle_after = !busy;
    cyc(DEB + 6);
  endtask

  task automatic test_reset;
    clr = 1; cyc(2);
    n_checks++; if (move_req !== 1'b0) begin n_fail++; $display("FAIL rst_move_req got %0b want 0", move_req); end
    n_checks++; if (move_dir !== 2'd0) begin n_fail++; $display("FAIL rst_move_dir got %0d want 0", move_dir); end
    n_checks++; if (spawn_req !== 1'b0) begin n_fail++; $display("FAIL rst_spawn_req got %0b want 0", spawn_req); end
    n_checks++; if (spawn_pos !== 4'd0) begin n_fail++; $display("FAIL rst_spawn_pos got %0d want 0", spawn_pos); end
    n_checks++; if (turns !== 14'd0) begin n_fail++; $display("FAIL rst_turns got %0d want 0", turns); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    clr = 0; m_turns = 0; m_last = 3;
  endtask

  task automatic test_clean_press;
    int r0;
    logic [3:0] ep;
    r0 = req_rises;
    set_btn(4'b0001); cyc(DEB + 10); set_btn(4'd0);
    n_checks++; if (move_req !== 1'b1) begin n_fail++; $display("FAIL clean_req got %0b want 1", move_req); end
    n_checks++; if (move_dir !== 2'd0) begin n_fail++; $display("FAIL clean_dir got %0d want 0", move_dir); end
    move_ack = 1; move_changed = 1; ep = m_lfsr[3:0];
    cyc(1); move_ack = 0; move_changed = 0;
    n_checks++; if (spawn_req !== 1'b1) begin n_fail++; $display("FAIL clean_spawn_req got %0b want 1", spawn_req); end
    n_checks++; if (spawn_pos !== ep) begin n_fail++; $display("FAIL clean_spawn_pos got %0d want %0d", spawn_pos, ep); end
    spawn_ack = 1; cyc(1); spawn_ack = 0; cyc(1);
    m_turns = 1; m_last = 0;
    n_checks++; if (turns !== 14'd1) begin n_fail++; $display("FAIL clean_turns got %0d want 1", turns); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy got %0b want 0", busy); end
    cyc(DEB + 6);
    n_checks++; if (req_rises - r0 != 1) begin n_fail++; $display("FAIL clean_req_count got %0d want 1", req_rises - r0); end
  endtask

  task automatic test_glitch;
    int r0;
    r0 = req_rises;
    set_btn(4'b0010); cyc(DEB - 2); set_btn(4'd0); cyc(DEB + 6);
    n_checks++; if (req_rises != r0) begin n_fail++; $display("FAIL short_press got %0d reqs want 0", req_rises - r0); end
    for (int i = 0; i < 10; i++) begin set_btn(4'b0100); cyc(3); set_btn(4'd0); cyc(3); end
    cyc(DEB + 6);
    n_checks++; if (req_rises != r0) begin n_fail++; $display("FAIL bounce got %0d reqs want 0", req_rises - r0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %0b want 0", busy); end
  endtask

  task automatic test_simultaneous;
    bit got, dok, sp, pok, idl;
    logic [1:0] dir, e;
    logic [3:0] pos, ep;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      e = exp_grant(4'b0101); m_last = e;
      run_turn(4'b0101, 0, 1, 0, got, dir, dok, sp, pos, ep, pok, idl);
      n_checks++; if (!got) begin n_fail++; $display("FAIL simul_timeout%0d no move_req want 1", n); end
      n_checks++; if (dir !== e) begin n_fail++; $display("FAIL simul_grant%0d got %0d want %0d", n, dir, e); end
    end
  endtask

  task automatic test_no_change;
    int r0;
    bit got;
    r0 = req_rises;
    set_btn(4'b0010); wait_req(got); set_btn(4'd0);
    n_checks++; if (!got) begin n_fail++; $display("FAIL nochg_timeout no move_req want 1"); end
    set_btn(4'b1000); cyc(DEB + 10);
    n_checks++; if (move_dir !== 2'd1) begin n_fail++; $display("FAIL nochg_dir got %0d want 1", move_dir); end
    move_ack = 1; move_changed = 0; cyc(1); move_ack = 0;
    n_checks++; if (spawn_req !== 1'b0) begin n_fail++; $display("FAIL nochg_spawn got %0b want 0", spawn_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nochg_busy got %0b want 0", busy); end
    cyc(DEB + 6);
    n_checks++; if (turns !== 14'(m_turns)) begin n_fail++; $display("FAIL nochg_turns got %0d want %0d", turns, m_turns); end
    n_checks++; if (req_rises - r0 != 1) begin n_fail++; $display("FAIL nochg_dropped got %0d reqs want 1", req_rises - r0); end
    set_btn(4'd0); cyc(DEB + 6);
    m_last = 1;
  endtask

  task automatic test_random;
    bit got, dok, sp, pok, idl, chg;
    logic [1:0] dir, e;
    logic [3:0] pos, ep, m;
    for (int n = 0; n < 25; n++) begin
      m = 4'($urandom_range(1, 15)); chg = 1'($urandom_range(0, 1));
      e = exp_grant(m); m_last = e;
      run_turn(m, chg, $urandom_range(0, 3), $urandom_range(0, 3), got, dir, dok, sp, pos, ep, pok, idl);
      if (chg && m_turns < TMAX) m_turns++;
      n_checks++; if (!got) begin n_fail++; $display("FAIL rand%0d_timeout no move_req want 1", n); end
      n_checks++; if (dir !== e || !dok) begin n_fail++; $display("FAIL rand%0d_dir got %0d stable %0b want %0d", n, dir, dok, e); end
      n_checks++; if (sp !== chg) begin n_fail++; $display("FAIL rand%0d_spawn got %0b want %0b", n, sp, chg); end
      if (chg) begin
        n_checks++; if (pos !== ep || !pok) begin n_fail++; $display("FAIL rand%0d_pos got %0d stable %0b want %0d", n, pos, pok, ep); end
      end
      n_checks++; if (turns !== 14'(m_turns) || !idl) begin n_fail++; $display("FAIL rand%0d_turns got %0d idle %0b want %0d", n, turns, idl, m_turns); end
    end
  endtask

  task automatic test_saturation;
    bit got, dok, sp, pok, idl;
    logic [1:0] dir;
    logic [3:0] pos, ep;
    while (m_turns < TMAX) begin
      run_turn(4'b0001, 1, 0, 0, got, dir, dok, sp, pos, ep, pok, idl);
      m_last = 0;
      if (!got || !sp) begin n_checks++; n_fail++; $display("FAIL sat_fill turn stalled got %0b spawn %0b want 1 1", got, sp); break; end
      m_turns++;
    end
    n_checks++; if (turns !== TMAX) begin n_fail++; $display("FAIL sat_reach got %0d want %0d", turns, TMAX); end
    run_turn(4'b0001, 1, 0, 0, got, dir, dok, sp, pos, ep, pok, idl);
    n_checks++; if (turns !== TMAX || !sp) begin n_fail++; $display("FAIL sat_hold got %0d spawn %0b want %0d 1", turns, sp, TMAX); end
  endtask

  task automatic test_halt;
    int r0;
    bit got, dok, sp, pok, idl;
    logic [1:0] dir;
    logic [3:0] pos, ep;
    set_btn(4'b0100); wait_req(got); set_btn(4'd0);
    move_ack = 1; move_changed = 1; cyc(1); move_ack = 0; move_changed = 0;
    n_checks++; if (spawn_req !== 1'b1) begin n_fail++; $display("FAIL halt_spawn_up got %0b want 1", spawn_req); end
    won = 1; cyc(1); won = 0;
    n_checks++; if (spawn_req !== 1'b0 || move_req !== 1'b0) begin n_fail++; $display("FAIL halt_reqs got %0b%0b want 00", move_req, spawn_req); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL halt_busy got %0b want 1", busy); end
    r0 = req_rises;
    set_btn(4'b1000); cyc(DEB + 10); set_btn(4'd0); cyc(4);
    n_checks++; if (req_rises != r0 || busy !== 1'b1) begin n_fail++; $display("FAIL halt_ignore got %0d reqs busy %0b want 0 1", req_rises - r0, busy); end
    n_checks++; if (turns !== 14'(m_turns)) begin n_fail++; $display("FAIL halt_turns got %0d want %0d", turns, m_turns); end
    clr = 1; cyc(1);
    n_checks++; if ({move_req, move_dir, spawn_req, spawn_pos, turns, busy} !== '0)
      begin n_fail++; $display("FAIL halt_clr got req %0b dir %0d sreq %0b pos %0d turns %0d busy %0b want all 0", move_req, move_dir, spawn_req, spawn_pos, turns, busy); end
    clr = 0; m_turns = 0; m_last = 3;
    run_turn(4'b0001, 1, 0, 0, got, dir, dok, sp, pos, ep, pok, idl);
    m_turns = 1; m_last = 0;
    set_btn(4'b0010); wait_req(got); set_btn(4'd0);
    move_ack = 1; move_changed = 1; lost = 1; cyc(1); {move_ack, move_changed, lost} = '0;
    n_checks++; if (spawn_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lost_ack got sreq %0b busy %0b want 0 1", spawn_req, busy); end
    cyc(3);
    n_checks++; if (turns !== 14'd1) begin n_fail++; $display("FAIL lost_turns got %0d want 1", turns); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_no_change();
    test_random();
    test_saturation();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
